// File: rtl/pip_2_gearbox.sv
// -----------------------------------------------------------------------------
// pip_2_gearbox
// Buffers 256-bit stream beats from the frontend register stage in a small
// FIFO and re-emits them as 64-bit words under a ready/valid handshake to the
// decoder core. The upstream side has no backpressure, so an almost-full flag
// is exported and beats arriving into a full FIFO are dropped and recorded in
// a sticky overflow flag.
//
// Ports
//   aclk        in   1    clock, rising edge
//   rst         in   1    asynchronous active-high reset
//   tdata_in    in   256  beat data, byte i = tdata_in[8i+7:8i]
//   tkeep_in    in   32   byte enables, contiguous from bit 0
//   tvalid_in   in   1    beat present this cycle (no ready returned)
//   tlast_in    in   1    last beat of frame
//   start       in   1    synchronous flush of FIFO, gearbox and overflow
//   tdata_out   out  64   output word, slice k = input bytes 8k..8k+7
//   tkeep_out   out  8    byte enables of the output word
//   tvalid_out  out  1    output word valid
//   tlast_out   out  1    last word of frame
//   tready_out  in   1    downstream accepts word on tvalid_out & tready_out
//   afull       out  1    registered: free FIFO entries <= AFULL
//   overflow    out  1    sticky: valid beat arrived while FIFO full
// -----------------------------------------------------------------------------
// Gearbox states
//   state  | meaning
//   S_IDLE | no beat loaded; waits for a non-empty FIFO
//   S_EMIT | FIFO head beat loaded; r_k is the slice being presented
// -----------------------------------------------------------------------------
module pip_2_gearbox #(
    parameter int DEPTH = 4,
    parameter int AFULL = 1
) (
    input  logic         aclk,
    input  logic         rst,
    input  logic [255:0] tdata_in,
    input  logic [31:0]  tkeep_in,
    input  logic         tvalid_in,
    input  logic         tlast_in,
    input  logic         start,
    output logic [63:0]  tdata_out,
    output logic [7:0]   tkeep_out,
    output logic         tvalid_out,
    output logic         tlast_out,
    input  logic         tready_out,
    output logic         afull,
    output logic         overflow
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    logic [255:0]  r_mem_data [DEPTH];
    logic [31:0]   r_mem_keep [DEPTH];
    logic          r_mem_last [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_afull;
    logic          r_overflow;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_k;
    logic [1:0]    w_k_nxt;

    logic [255:0]  w_head_data;
    logic [31:0]   w_head_keep;
    logic          w_head_last;
    logic [5:0]    w_pc;
    logic [2:0]    w_nbytes8;
    logic [2:0]    w_nwords;
    logic [2:0]    w_last_k;
    logic          w_discard;
    logic          w_emit;
    logic          w_hs;
    logic          w_final;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic [AW-1:0] w_waddr;
    logic [AW:0]   w_count_nxt;
    logic          w_afull_nxt;
    logic [63:0]   w_slice_data;
    logic [7:0]    w_slice_keep;

    // The head entry stays put until it pops, so the output can be taken
    // straight from FIFO storage without a separate holding register.
    assign w_head_data = r_mem_data[r_rptr];
    assign w_head_keep = r_mem_keep[r_rptr];
    assign w_head_last = r_mem_last[r_rptr];

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < 32; i++) begin
            w_pc = w_pc + 6'(w_head_keep[i]);
        end
    end

    // Words per beat: ceil(popcount/8); an empty last beat still emits one
    // (keep=0) word so the frame boundary reaches the decoder.
    assign w_nbytes8 = 3'((w_pc + 6'd7) >> 3);
    assign w_nwords  = (w_nbytes8 == 3'd0) ? 3'd1 : w_nbytes8;
    assign w_last_k  = w_nwords - 3'd1;
    assign w_discard = (w_nbytes8 == 3'd0) && !w_head_last;

    assign w_emit  = (r_state == S_EMIT) && !w_discard;
    assign w_hs    = w_emit && tready_out;
    assign w_final = ({1'b0, r_k} == w_last_k);
    assign w_pop   = (r_state == S_EMIT) && (w_discard || (w_hs && w_final));

    // Full is judged after a same-edge pop so the freed slot can be reused.
    assign w_full  = (r_count == C_DEPTH) && !w_pop;
    assign w_wr    = tvalid_in && (start || !w_full);
    assign w_waddr = start ? '0 : r_wptr;

    assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    assign w_afull_nxt = (DEPTH - int'(w_count_nxt)) <= AFULL;

    always_comb begin
        w_slice_data = w_head_data[63:0];
        w_slice_keep = w_head_keep[7:0];
        case (r_k)
            2'd1: begin
                w_slice_data = w_head_data[127:64];
                w_slice_keep = w_head_keep[15:8];
            end
            2'd2: begin
                w_slice_data = w_head_data[191:128];
                w_slice_keep = w_head_keep[23:16];
            end
            2'd3: begin
                w_slice_data = w_head_data[255:192];
                w_slice_keep = w_head_keep[31:24];
            end
            default: begin
                w_slice_data = w_head_data[63:0];
                w_slice_keep = w_head_keep[7:0];
            end
        endcase
    end

    assign tvalid_out = w_emit;
    assign tdata_out  = w_emit ? w_slice_data : '0;
    assign tkeep_out  = w_emit ? w_slice_keep : '0;
    assign tlast_out  = w_emit && w_head_last && w_final;
    assign afull      = r_afull;
    assign overflow   = r_overflow;

    // Gearbox state register
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Gearbox next state
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_EMIT;
                    w_k_nxt     = '0;
                end
            end
            S_EMIT: begin
                if (w_pop) begin
                    w_k_nxt     = '0;
                    // Only beats already queued behind the head are loaded on
                    // the pop edge; a same-edge write goes through IDLE.
                    w_state_nxt = (r_count > (AW+1)'(1)) ? S_EMIT : S_IDLE;
                end else if (w_hs) begin
                    w_k_nxt = r_k + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = '0;
            end
        endcase
        if (start) begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = '0;
        end
    end

    // FIFO control
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (start) begin
            r_wptr     <= AW'(w_wr);
            r_rptr     <= '0;
            r_count    <= (AW+1)'(w_wr);
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_afull <= w_afull_nxt;
            if (tvalid_in && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem_data[w_waddr] <= tdata_in;
            r_mem_keep[w_waddr] <= tkeep_in;
            r_mem_last[w_waddr] <= tlast_in;
        end
    end

endmodule

// File: tb/tb_pip_2_gearbox.sv
module tb_pip_2_gearbox;

    logic         aclk = 1'b0;
    logic         rst;
    logic [255:0] tdata_in;
    logic [31:0]  tkeep_in;
    logic         tvalid_in;
    logic         tlast_in;
    logic         start;
    logic [63:0]  tdata_out;
    logic [7:0]   tkeep_out;
    logic         tvalid_out;
    logic         tlast_out;
    logic         tready_out;
    logic         afull;
    logic         overflow;

    pip_2_gearbox #(.DEPTH(4), .AFULL(1)) dut (
        .aclk       (aclk),
        .rst        (rst),
        .tdata_in   (tdata_in),
        .tkeep_in   (tkeep_in),
        .tvalid_in  (tvalid_in),
        .tlast_in   (tlast_in),
        .start      (start),
        .tdata_out  (tdata_out),
        .tkeep_out  (tkeep_out),
        .tvalid_out (tvalid_out),
        .tlast_out  (tlast_out),
        .tready_out (tready_out),
        .afull      (afull),
        .overflow   (overflow)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        cd;
    } word_t;

    word_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: a beat becomes ceil(bytes/8) words; an empty last beat
    // becomes one keep=0 word; an empty non-last beat becomes nothing.
    task automatic push_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        int    nb;
        word_t w;
        nb = ($countones(k) + 7) / 8;
        if (nb == 0) begin
            if (l) begin
                w.d = '0; w.k = '0; w.l = 1'b1; w.cd = 1'b0;
                sb.push_back(w);
            end
        end else begin
            for (int j = 0; j < nb; j++) begin
                w.d  = d[64*j +: 64];
                w.k  = k[8*j +: 8];
                w.l  = l && (j == nb - 1);
                w.cd = 1'b1;
                sb.push_back(w);
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic put(input logic [255:0] d, input logic [31:0] k, input logic l, input bit acc);
        tdata_in  = d;
        tkeep_in  = k;
        tlast_in  = l;
        tvalid_in = 1'b1;
        if (acc) push_beat(d, k, l);
    endtask

    task automatic drive(input logic [255:0] d, input logic [31:0] k, input logic l, input bit acc);
        tick();
        start = 1'b0;
        put(d, k, l, acc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            tvalid_in = 1'b0;
            start     = 1'b0;
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge aclk) begin
        word_t e;
        if (!rst && tvalid_out && tready_out) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: got data %h keep %h last %b, expected no word",
                         tdata_out, tkeep_out, tlast_out);
            end else begin
                e = sb.pop_front();
                if (tkeep_out !== e.k || tlast_out !== e.l || (e.cd && tdata_out !== e.d)) begin
                    failures++;
                    $display("FAIL word: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                             tdata_out, tkeep_out, tlast_out, e.d, e.k, e.l);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;
        logic [255:0] dd [5];
        logic [32:0]  m;
        int           nb;
        int           gap;
        logic         l;

        rst = 1'b1; tdata_in = '0; tkeep_in = '0; tvalid_in = 1'b0;
        tlast_in = 1'b0; start = 1'b0; tready_out = 1'b1;
        #2;
        chk("rst_tvalid", 64'(tvalid_out), 64'd0);
        chk("rst_tdata", tdata_out, 64'd0);
        chk("rst_tkeep", 64'(tkeep_out), 64'd0);
        chk("rst_tlast", 64'(tlast_out), 64'd0);
        chk("rst_afull", 64'(afull), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        idle(1);

        // Full beat: four words on consecutive cycles, tlast on the fourth.
        d = rnd256();
        drive(d, 32'hFFFF_FFFF, 1'b1, 1'b1);
        idle(1); chk("t1_lat_early", 64'(tvalid_out), 64'd0);
        idle(1); chk("t1_lat", 64'(tvalid_out), 64'd1);
        idle(1); chk("t1_w1_valid", 64'(tvalid_out), 64'd1);
        idle(1); chk("t1_w2_valid", 64'(tvalid_out), 64'd1);
                 chk("t1_w2_nolast", 64'(tlast_out), 64'd0);
        idle(1); chk("t1_w3_last", 64'(tlast_out), 64'd1);
        idle(1); chk("t1_done", 64'(tvalid_out), 64'd0);
        chk("t1_drain", 64'(sb.size()), 64'd0);

        // Partial beat, discarded empty beat, empty last beat.
        drive(rnd256(), 32'h0000_0FFF, 1'b1, 1'b1);
        drive(rnd256(), 32'h0000_0000, 1'b0, 1'b1);
        idle(8);
        chk("t2_drain", 64'(sb.size()), 64'd0);
        drive(rnd256(), 32'h0000_0000, 1'b1, 1'b1);
        idle(6);
        chk("t2_empty_last_drain", 64'(sb.size()), 64'd0);

        // Backpressure holds the word stable.
        tready_out = 1'b0;
        d = rnd256();
        drive(d, 32'hFFFF_FFFF, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 64'(tvalid_out), 64'd1);
            chk("t3_hold_data", tdata_out, d[63:0]);
            chk("t3_hold_keep", 64'(tkeep_out), 64'hFF);
            idle(1);
        end
        tready_out = 1'b1;
        idle(6);
        chk("t3_drain", 64'(sb.size()), 64'd0);

        // Five back-to-back full beats into a stalled gearbox.
        tready_out = 1'b0;
        for (int i = 0; i < 5; i++) dd[i] = rnd256();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) chk("t4_afull_after2", 64'(afull), 64'd0);
            if (i == 3) chk("t4_afull_after3", 64'(afull), 64'd1);
            if (i == 4) chk("t4_no_ovf_yet", 64'(overflow), 64'd0);
            put(dd[i], 32'hFFFF_FFFF, (i == 3), (i < 4));
        end
        idle(1); chk("t4_overflow", 64'(overflow), 64'd1);
        idle(3); chk("t4_overflow_sticky", 64'(overflow), 64'd1);
        tready_out = 1'b1;
        idle(22);
        chk("t4_drain", 64'(sb.size()), 64'd0);
        chk("t4_overflow_kept", 64'(overflow), 64'd1);
        chk("t4_afull_clear", 64'(afull), 64'd0);

        // Full FIFO: final word pops on the same edge a new beat arrives.
        tick(); start = 1'b1; tvalid_in = 1'b0;
        idle(1);
        chk("t5_start_clr_ovf", 64'(overflow), 64'd0);
        tready_out = 1'b0;
        for (int i = 0; i < 4; i++) drive(rnd256(), 32'h0000_00FF, 1'b1, 1'b1);
        tick();
        tvalid_in = 1'b0;
        chk("t5_full_afull", 64'(afull), 64'd1);
        tready_out = 1'b1;
        put(rnd256(), 32'h0000_00FF, 1'b1, 1'b1);
        tick();
        tready_out = 1'b0;
        chk("t5_accept_no_ovf", 64'(overflow), 64'd0);
        chk("t5_afull_held", 64'(afull), 64'd1);
        put(rnd256(), 32'h0000_00FF, 1'b1, 1'b0);
        tick();
        tvalid_in = 1'b0;
        chk("t5_count_still_full", 64'(overflow), 64'd1);
        tready_out = 1'b1;
        idle(12);
        chk("t5_drain", 64'(sb.size()), 64'd0);

        // start mid-frame with a coincident beat.
        tick(); start = 1'b1; tvalid_in = 1'b0;
        idle(1);
        tready_out = 1'b0;
        for (int i = 0; i < 5; i++) drive(rnd256(), 32'hFFFF_FFFF, (i == 1), (i < 4));
        idle(2);
        chk("t6_pre_overflow", 64'(overflow), 64'd1);
        chk("t6_pre_valid", 64'(tvalid_out), 64'd1);
        tick();
        sb.delete();
        start = 1'b1;
        put(rnd256(), 32'h0000_00FF, 1'b1, 1'b1);
        tick();
        start = 1'b0; tvalid_in = 1'b0;
        chk("t6_start_valid", 64'(tvalid_out), 64'd0);
        chk("t6_start_ovf", 64'(overflow), 64'd0);
        chk("t6_start_afull", 64'(afull), 64'd0);
        tready_out = 1'b1;
        idle(6);
        chk("t6_drain", 64'(sb.size()), 64'd0);

        // Reset while a word is being presented.
        tready_out = 1'b0;
        drive(rnd256(), 32'hFFFF_FFFF, 1'b1, 1'b1);
        idle(2);
        chk("t7_pre_valid", 64'(tvalid_out), 64'd1);
        rst = 1'b1;
        #1;
        chk("t7_rst_valid", 64'(tvalid_out), 64'd0);
        chk("t7_rst_data", tdata_out, 64'd0);
        chk("t7_rst_keep", 64'(tkeep_out), 64'd0);
        chk("t7_rst_last", 64'(tlast_out), 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tready_out = 1'b1;
        idle(6);
        chk("t7_post_valid", 64'(tvalid_out), 64'd0);

        // Randomized traffic with random backpressure, paced to avoid overflow.
        gap = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            tvalid_in  = 1'b0;
            start      = 1'b0;
            tready_out = ($urandom_range(0, 9) < 7);
            if (gap > 0) begin
                gap--;
            end else if (sb.size() <= 2 && $urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 32));
                l  = ($urandom_range(0, 3) == 0);
                if (nb == 0 && !l) begin
                    if (sb.size() != 0) l = 1'b1;
                    else gap = 3;
                end
                m = (33'd1 << nb) - 33'd1;
                put(rnd256(), m[31:0], l, 1'b1);
            end
        end
        tick();
        tvalid_in  = 1'b0;
        tready_out = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
        chk("rand_drain", 64'(sb.size()), 64'd0);
        chk("rand_no_overflow", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
